// File: rtl/cmd_parser.sv
// ASCII expression parser: turns a byte stream of the form "<a><op><b>=" into
// two binary operands and a one-hot operation code, with error and escape handling.
module cmd_parser #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned OPW    = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           strt,
  input  logic [7:0]     data,
  output logic [OPW-1:0] op_a,
  output logic [OPW-1:0] op_b,
  output logic [3:0]     cmd,
  output logic           rdy,
  output logic           err
);

  localparam int unsigned EW = OPW + 4;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  localparam logic [2:0] S_A0  = 3'd0;
  localparam logic [2:0] S_A   = 3'd1;
  localparam logic [2:0] S_B0  = 3'd2;
  localparam logic [2:0] S_B   = 3'd3;
  localparam logic [2:0] S_ERR = 3'd4;

  logic [2:0]     state, state_nxt;
  logic [OPW-1:0] acc_a, acc_a_nxt, acc_b, acc_b_nxt;
  logic [OPW-1:0] op_a_nxt, op_b_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [3:0]     code, code_nxt, cmd_nxt;
  logic           rdy_nxt, err_nxt;

  logic           is_dig, is_op, is_eq, is_esc, is_bs;
  logic [3:0]     digit, op_code;
  logic [EW-1:0]  ext_a, ext_b;
  logic           ovf_a, ovf_b, cnt_full;

  // Byte classification and decimal accumulation at extended width
  always_comb begin
    is_dig   = (data >= 8'h30) && (data <= 8'h39);
    is_eq    = (data == 8'h3D) || (data == 8'h0D);
    is_esc   = (data == 8'h1B);
    is_bs    = (data == 8'h08);
    digit    = data[3:0];
    is_op    = 1'b1;
    op_code  = 4'b0000;
    case (data)
      8'h2B:   op_code = 4'b0001;
      8'h2D:   op_code = 4'b0010;
      8'h2A:   op_code = 4'b0100;
      8'h2F:   op_code = 4'b1000;
      default: is_op   = 1'b0;
    endcase
    ext_a    = EW'(acc_a) * EW'(10) + EW'(digit);
    ext_b    = EW'(acc_b) * EW'(10) + EW'(digit);
    ovf_a    = |ext_a[EW-1:OPW];
    ovf_b    = |ext_b[EW-1:OPW];
    cnt_full = (cnt >= CW'(DIGITS));
  end

  // Next-state and output decode
  always_comb begin
    state_nxt = state;
    acc_a_nxt = acc_a;
    acc_b_nxt = acc_b;
    cnt_nxt   = cnt;
    code_nxt  = code;
    op_a_nxt  = op_a;
    op_b_nxt  = op_b;
    cmd_nxt   = cmd;
    rdy_nxt   = 1'b0;
    err_nxt   = err;
    if (strt) begin
      if (is_esc) begin
        state_nxt = S_A0;
        acc_a_nxt = '0;
        acc_b_nxt = '0;
        cnt_nxt   = '0;
        code_nxt  = '0;
        err_nxt   = 1'b0;
      end else begin
        case (state)
          S_A0: begin
            if (is_dig) begin
              acc_a_nxt = OPW'(digit);
              cnt_nxt   = CW'(1);
              cmd_nxt   = 4'b0000;
              state_nxt = S_A;
            end
          end
          S_A: begin
            if (is_dig) begin
              if (cnt_full || ovf_a) begin
                state_nxt = S_ERR;
                err_nxt   = 1'b1;
              end else begin
                acc_a_nxt = ext_a[OPW-1:0];
                cnt_nxt   = cnt + CW'(1);
              end
            end else if (is_op) begin
              code_nxt  = op_code;
              cnt_nxt   = '0;
              state_nxt = S_B0;
            end else if (is_bs) begin
              acc_a_nxt = '0;
              cnt_nxt   = '0;
              state_nxt = S_A0;
            end
          end
          S_B0: begin
            if (is_dig) begin
              acc_b_nxt = OPW'(digit);
              cnt_nxt   = CW'(1);
              state_nxt = S_B;
            end
          end
          S_B: begin
            if (is_dig) begin
              if (cnt_full || ovf_b) begin
                state_nxt = S_ERR;
                err_nxt   = 1'b1;
              end else begin
                acc_b_nxt = ext_b[OPW-1:0];
                cnt_nxt   = cnt + CW'(1);
              end
            end else if (is_eq) begin
              op_a_nxt  = acc_a;
              op_b_nxt  = acc_b;
              cmd_nxt   = code;
              rdy_nxt   = 1'b1;
              state_nxt = S_A0;
            end else if (is_bs) begin
              acc_b_nxt = '0;
              cnt_nxt   = '0;
              state_nxt = S_B0;
            end
          end
          S_ERR: begin
            if (is_eq) begin
              state_nxt = S_A0;
              err_nxt   = 1'b0;
            end
          end
          default: state_nxt = S_A0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_A0;
      acc_a <= '0;
      acc_b <= '0;
      cnt   <= '0;
      code  <= '0;
      op_a  <= '0;
      op_b  <= '0;
      cmd   <= '0;
      rdy   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc_a <= acc_a_nxt;
      acc_b <= acc_b_nxt;
      cnt   <= cnt_nxt;
      code  <= code_nxt;
      op_a  <= op_a_nxt;
      op_b  <= op_b_nxt;
      cmd   <= cmd_nxt;
      rdy   <= rdy_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser: table of byte streams with hand-computed
// results, plus burst-strobe and asynchronous-reset sequences.
module tb_cmd_parser;

  localparam int unsigned OPW = 10;

  logic           clk  = 1'b0;
  logic           rst  = 1'b0;
  logic           strt = 1'b0;
  logic [7:0]     data = 8'h00;
  logic [OPW-1:0] op_a, op_b;
  logic [3:0]     cmd;
  logic           rdy, err;

  cmd_parser #(.DIGITS(3), .OPW(OPW)) dut (
    .clk  (clk),
    .rst  (rst),
    .strt (strt),
    .data (data),
    .op_a (op_a),
    .op_b (op_b),
    .cmd  (cmd),
    .rdy  (rdy),
    .err  (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rdy_cnt  = 0;

  always @(negedge clk) if (rdy) rdy_cnt <= rdy_cnt + 1;

  typedef struct {
    logic [63:0] s;
    int          len;
    int          a;
    int          b;
    int          c;
    int          e;
    int          r;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    strt = 1'b1;
    data = b;
    @(negedge clk);
    strt = 1'b0;
    data = 8'h00;
  endtask

  initial begin
    logic [39:0] burst;
    logic [23:0] pre;
    logic [31:0] post;
    int          base;

    vecs[0] = '{64'("12+34="),   6,  12,  34, 1, 0, 1};
    vecs[1] = '{64'("999*999="), 8, 999, 999, 4, 0, 1};
    vecs[2] = '{64'("1234"),     4, 999, 999, 0, 1, 0};
    vecs[3] = '{64'("="),        1, 999, 999, 0, 0, 0};
    vecs[4] = '{64'({"5", 8'h1B, "7/2="}),  6, 7, 2, 8, 0, 1};
    vecs[5] = '{64'({"19", 8'h08, "2-1="}), 7, 2, 1, 2, 0, 1};
    vecs[6] = '{64'("6+*=+7*="), 8,   6,   7, 1, 0, 1};
    vecs[7] = '{64'({"4/5", 8'h08, "3="}),  6, 4, 3, 8, 0, 1};
    vecs[8] = '{64'("1+2345"),   6,   4,   3, 0, 1, 0};
    vecs[9] = '{64'(8'h1B),      1,   4,   3, 0, 0, 0};

    // Reset state
    #12;
    chk("reset_op_a", int'(op_a), 0);
    chk("reset_op_b", int'(op_b), 0);
    chk("reset_cmd",  int'(cmd),  0);
    chk("reset_rdy",  int'(rdy),  0);
    chk("reset_err",  int'(err),  0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      base = rdy_cnt;
      for (int j = 0; j < vecs[i].len; j++)
        send(vecs[i].s[8*(vecs[i].len-1-j) +: 8]);
      repeat (2) @(negedge clk);
      #1;
      chk($sformatf("v%0d_op_a", i), int'(op_a), vecs[i].a);
      chk($sformatf("v%0d_op_b", i), int'(op_b), vecs[i].b);
      chk($sformatf("v%0d_cmd", i),  int'(cmd),  vecs[i].c);
      chk($sformatf("v%0d_err", i),  int'(err),  vecs[i].e);
      chk($sformatf("v%0d_rdy_pulses", i), rdy_cnt - base, vecs[i].r);
    end

    // Strobe held high across five consecutive bytes
    burst = "8+1=x";
    base  = rdy_cnt;
    @(negedge clk);
    strt = 1'b1;
    for (int j = 0; j < 5; j++) begin
      data = burst[8*(4-j) +: 8];
      @(negedge clk);
    end
    strt = 1'b0;
    data = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("burst_op_a", int'(op_a), 8);
    chk("burst_op_b", int'(op_b), 1);
    chk("burst_cmd",  int'(cmd),  1);
    chk("burst_err",  int'(err),  0);
    chk("burst_rdy_pulses", rdy_cnt - base, 1);

    // Asynchronous reset in the middle of an expression
    pre = "12+";
    for (int j = 0; j < 3; j++) send(pre[8*(2-j) +: 8]);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_op_a", int'(op_a), 0);
    chk("async_op_b", int'(op_b), 0);
    chk("async_cmd",  int'(cmd),  0);
    chk("async_rdy",  int'(rdy),  0);
    chk("async_err",  int'(err),  0);
    @(negedge clk);
    rst = 1'b1;

    post = "3-4=";
    base = rdy_cnt;
    for (int j = 0; j < 4; j++) send(post[8*(3-j) +: 8]);
    #1;
    chk("post_rdy_high", int'(rdy),  1);
    chk("post_op_a",     int'(op_a), 3);
    chk("post_op_b",     int'(op_b), 4);
    chk("post_cmd",      int'(cmd),  2);
    @(negedge clk);
    #1;
    chk("post_rdy_low",  int'(rdy),  0);
    chk("post_rdy_pulses", rdy_cnt - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 Parameter DIGITS, default 3: maximum decimal digits accepted per operand.
REQ-002 Parameter OPW, default 10: operand width in bits.
REQ-003 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 strt  input  1  byte-valid strobe; data is consumed on each rising clk edge where strt=1.
REQ-006 data  input  8  ASCII byte, valid whenever strt=1.
REQ-007 op_a  output  OPW  first operand of the last completed expression.
REQ-008 op_b  output  OPW  second operand of the last completed expression.
REQ-009 cmd  output  4  one-hot operation: 0001 '+', 0010 '-', 0100 '*', 1000 '/', 0000 none.
REQ-010 rdy  output  1  one-cycle pulse marking a newly completed expression.
REQ-011 err  output  1  level; high while the parser is in the error state.

Function
REQ-012 Byte classes SHALL be: digit 0x30-0x39; operator 0x2B/0x2D/0x2A/0x2F; equals 0x3D or 0x0D; escape 0x1B; backspace 0x08; any other byte ignored (no state change).
REQ-013 Bytes SHALL be sampled on the same edge as strt, with no input delay stage; strt high for k consecutive cycles consumes k bytes.
REQ-014 The FSM SHALL have exactly these states: A0 (await first A digit), A (accumulate A), B0 (await first B digit), B (accumulate B), ERR.
REQ-015 A0 + digit: acc_a = digit, cnt = 1, cmd cleared to 0000, go to A; all other classes are ignored.
REQ-016 A + digit: acc_a = acc_a*10 + digit, cnt += 1; A + operator: latch the operator code, cnt = 0, go to B0.
REQ-017 B0 + digit: acc_b = digit, cnt = 1, go to B; operators and equals in B0 are ignored.
REQ-018 B + digit: acc_b = acc_b*10 + digit; B + equals: op_a <= acc_a, op_b <= acc_b, cmd <= latched code, rdy = 1 for one cycle, go to A0.
REQ-019 An operator received in B SHALL be ignored.
REQ-020 Arithmetic SHALL be evaluated at OPW+4 bits; a digit making cnt exceed DIGITS, or a result exceeding 2^OPW-1, SHALL go to ERR with err=1 and leave accumulators unchanged.
REQ-021 ERR: only escape or equals exits, to A0 with err=0; rdy SHALL NOT pulse; op_a, op_b and cmd are held.
REQ-022 Escape in any state: go to A0, clear accumulators, cnt, latched code and err; op_a, op_b and cmd are held.
REQ-023 Backspace in A or B: clear the current accumulator and cnt, return to A0 or B0 respectively; in other states it is ignored.
REQ-024 rdy SHALL be registered: high exactly the cycle after the equals edge, with op_a, op_b and cmd already valid in that cycle.
REQ-025 op_a, op_b and cmd SHALL hold their values until the next completion, the next A0 first digit (cmd only), or reset.

Reset
REQ-026 rst=0 SHALL immediately force: state A0; op_a, op_b, accumulators and cnt to 0; cmd 0000; rdy 0; err 0.
REQ-027 Reset asserted mid-expression SHALL discard the partial expression; parsing restarts at A0 on the first strt after release.

Verification (DIGITS=3, OPW=10)
REQ-028 Stream "12+34=" -> a single rdy pulse; op_a=12, op_b=34, cmd=0001.
REQ-029 Stream "999*999=" -> op_a=999, op_b=999, cmd=0100, err stays 0.
REQ-030 Stream "1234" -> err=1 after the 4th digit; then "=" -> err=0, no rdy, outputs unchanged.
REQ-031 Stream "5", ESC, "7/2=" -> op_a=7, op_b=2, cmd=1000.
REQ-032 Stream "19", 0x08, "2-1=" -> op_a=2, op_b=1, cmd=0010; strt held high for 5 cycles over "8+1=x" -> op_a=8, op_b=1, cmd=0001, 'x' ignored.
REQ-033 Stream "12+", rst pulsed low asynchronously between edges -> all outputs 0 at once; then "3-4=" -> op_a=3, op_b=4, cmd=0010.
